// File: rtl/stk_pipe_wrbk.sv
// stk_pipe_wrbk: writeback stage of the stack pipe; commits per-engine context,
// holds one response per engine and queues freed line pointers for the allocator.
module stk_pipe_wrbk #(
    parameter int ENGS_N      = 4,
    parameter int PTR_W       = 8,
    parameter int DAT_W       = 128,
    parameter int DEALLOC_Q_N = 4,
    localparam int ENG_W = ENGS_N > 1 ? $clog2(ENGS_N) : 1,
    localparam int QA_W  = $clog2(DEALLOC_Q_N)
) (
    input  logic                        clk,
    input  logic                        arst,
    input  logic                        i_wrbk_uc_vld_r,
    input  logic [ENG_W-1:0]            i_wrbk_uc_engid_r,
    input  logic [1:0]                  i_wrbk_uc_opcode_r,
    input  logic                        i_wrbk_uc_head_vld_r,
    input  logic [PTR_W-1:0]            i_wrbk_uc_head_ptr_r,
    input  logic                        i_wrbk_uc_tail_vld_r,
    input  logic [PTR_W-1:0]            i_wrbk_uc_tail_ptr_r,
    input  logic [DAT_W-1:0]            i_wrbk_dat_r,
    output logic [ENGS_N-1:0]           o_ctx_head_vld,
    output logic [ENGS_N*PTR_W-1:0]     o_ctx_head_ptr,
    output logic [ENGS_N-1:0]           o_ctx_tail_vld,
    output logic [ENGS_N*PTR_W-1:0]     o_ctx_tail_ptr,
    output logic [ENGS_N*(PTR_W+1)-1:0] o_ctx_cnt,
    output logic [ENGS_N-1:0]           o_rsp_vld,
    output logic [ENGS_N-1:0]           o_rsp_err,
    output logic [ENGS_N*DAT_W-1:0]     o_rsp_dat,
    input  logic [ENGS_N-1:0]           i_rsp_ack,
    output logic                        o_rsp_ovf,
    output logic                        o_dealloc_vld,
    output logic [PTR_W-1:0]            o_dealloc_ptr,
    input  logic                        i_dealloc_rdy,
    output logic                        o_dealloc_full,
    output logic                        o_dealloc_drop
);
    localparam logic [1:0] OP_NOP  = 2'd0;
    localparam logic [1:0] OP_PUSH = 2'd1;
    localparam logic [1:0] OP_POP  = 2'd2;
    localparam logic [1:0] OP_INSP = 2'd3;
    localparam logic [PTR_W:0] CNT_MAX = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0] CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

    logic [ENGS_N-1:0]                  head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic [ENGS_N-1:0][PTR_W-1:0]       head_ptr_q, head_ptr_d, tail_ptr_q, tail_ptr_d;
    logic [ENGS_N-1:0][PTR_W:0]         cnt_q, cnt_d;
    logic [ENGS_N-1:0]                  rsp_vld_q, rsp_vld_d, rsp_err_q, rsp_err_d;
    logic [ENGS_N-1:0][DAT_W-1:0]       rsp_dat_q, rsp_dat_d;
    logic                               rsp_ovf_q, rsp_ovf_d, drop_q, drop_d;
    logic [QA_W:0]                      wr_q, wr_d, rd_q, rd_d, occ;
    logic [DEALLOC_Q_N-1:0][PTR_W-1:0]  mem_q, mem_d;
    logic [PTR_W:0]                     cur_cnt;
    logic                               is_push, is_pop, is_insp, push_ok, pop_ok, rsp_new, deq, enq;

    assign cur_cnt = cnt_q[i_wrbk_uc_engid_r];
    assign is_push = i_wrbk_uc_vld_r && i_wrbk_uc_opcode_r == OP_PUSH;
    assign is_pop  = i_wrbk_uc_vld_r && i_wrbk_uc_opcode_r == OP_POP;
    assign is_insp = i_wrbk_uc_vld_r && i_wrbk_uc_opcode_r == OP_INSP;
    assign rsp_new = i_wrbk_uc_vld_r && i_wrbk_uc_opcode_r != OP_NOP;
    assign push_ok = is_push && cur_cnt != CNT_MAX;
    assign pop_ok  = is_pop && cur_cnt != '0;
    assign occ     = wr_q - rd_q;
    assign deq     = wr_q != rd_q && i_dealloc_rdy;
    // A full queue still accepts a freed pointer when an entry leaves in the same cycle.
    assign enq     = pop_ok && (occ != (QA_W+1)'(DEALLOC_Q_N) || deq);

    always_comb begin
        head_vld_d = head_vld_q;
        head_ptr_d = head_ptr_q;
        tail_vld_d = tail_vld_q;
        tail_ptr_d = tail_ptr_q;
        cnt_d      = cnt_q;
        rsp_vld_d  = rsp_vld_q & ~i_rsp_ack;
        rsp_err_d  = rsp_err_q;
        rsp_dat_d  = rsp_dat_q;
        rsp_ovf_d  = 1'b0;
        if (push_ok || pop_ok) begin
            head_vld_d[i_wrbk_uc_engid_r] = i_wrbk_uc_head_vld_r;
            head_ptr_d[i_wrbk_uc_engid_r] = i_wrbk_uc_head_ptr_r;
            tail_vld_d[i_wrbk_uc_engid_r] = i_wrbk_uc_tail_vld_r;
            tail_ptr_d[i_wrbk_uc_engid_r] = i_wrbk_uc_tail_ptr_r;
            cnt_d[i_wrbk_uc_engid_r]      = push_ok ? cur_cnt + CNT_ONE : cur_cnt - CNT_ONE;
        end
        if (rsp_new) begin
            rsp_vld_d[i_wrbk_uc_engid_r] = 1'b1;
            rsp_err_d[i_wrbk_uc_engid_r] = (is_push && !push_ok) || (is_pop && !pop_ok) || (is_insp && cur_cnt == '0);
            rsp_dat_d[i_wrbk_uc_engid_r] = (pop_ok || is_insp) ? i_wrbk_dat_r : '0;
            rsp_ovf_d = rsp_vld_q[i_wrbk_uc_engid_r] && !i_rsp_ack[i_wrbk_uc_engid_r];
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (enq) mem_d[wr_q[QA_W-1:0]] = head_ptr_q[i_wrbk_uc_engid_r];
        wr_d   = wr_q + {{QA_W{1'b0}}, enq};
        rd_d   = rd_q + {{QA_W{1'b0}}, deq};
        drop_d = drop_q || (pop_ok && !enq);
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            head_vld_q <= '0;
            head_ptr_q <= '0;
            tail_vld_q <= '0;
            tail_ptr_q <= '0;
            cnt_q      <= '0;
            rsp_vld_q  <= '0;
            rsp_err_q  <= '0;
            rsp_dat_q  <= '0;
            rsp_ovf_q  <= 1'b0;
            drop_q     <= 1'b0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            head_vld_q <= head_vld_d;
            head_ptr_q <= head_ptr_d;
            tail_vld_q <= tail_vld_d;
            tail_ptr_q <= tail_ptr_d;
            cnt_q      <= cnt_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_dat_q  <= rsp_dat_d;
            rsp_ovf_q  <= rsp_ovf_d;
            drop_q     <= drop_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign o_ctx_head_vld = head_vld_q;
    assign o_ctx_head_ptr = head_ptr_q;
    assign o_ctx_tail_vld = tail_vld_q;
    assign o_ctx_tail_ptr = tail_ptr_q;
    assign o_ctx_cnt      = cnt_q;
    assign o_rsp_vld      = rsp_vld_q;
    assign o_rsp_err      = rsp_err_q;
    assign o_rsp_dat      = rsp_dat_q;
    assign o_rsp_ovf      = rsp_ovf_q;
    assign o_dealloc_vld  = wr_q != rd_q;
    assign o_dealloc_ptr  = mem_q[rd_q[QA_W-1:0]];
    assign o_dealloc_full = occ >= (QA_W+1)'(DEALLOC_Q_N - 2);
    assign o_dealloc_drop = drop_q;
endmodule
